rom_port_arbiter: RTL and testbench
===================================

# rom_port_arbiter

Two-requester arbiter that shares the single read port of the instruction ROM (10-bit word address, 32-bit word data, combinational read) between the instruction-fetch unit (port 0) and the debug/load port (port 1). It accepts one request at a time with valid/ready handshakes and applies round-robin priority. It registers the ROM address, captures the returned word, and holds the response until the winning requester takes it. It sits between the fetch/debug logic and the ROM, and is the only driver of the ROM address.

## Interface
- ADDR_W, 10, ROM word-address width (1024 words)
- DATA_W, 32, ROM word width
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid / req1_valid  in  1  request pending on port 0 / 1
- req0_addr / req1_addr  in  ADDR_W  word address; must be held stable while valid and not ready
- req0_ready / req1_ready  out  1  request accepted this cycle (combinational)
- rsp0_valid / rsp1_valid  out  1  response word available
- rsp_data  out  DATA_W  response word, shared by both ports; qualified by rspN_valid
- rsp0_ready / rsp1_ready  in  1  requester takes the response
- rom_addr  out  ADDR_W  registered address to ROM
- rom_data  in  DATA_W  ROM read data; valid one cycle after rom_addr changes
- busy  out  1  high in any state other than IDLE

## Operation
- States:
  - IDLE: arbitrate.
  - READ: ROM address presented, data settling.
  - RESP: response held.
- IDLE, arbitration:
  - If exactly one reqN_valid is high, that port wins.
  - If both are high, the port not equal to last_grant wins.
  - On a win: reqN_ready=1 that cycle, rom_addr<=reqN_addr, owner<=N, last_grant<=N, next state READ.
  - No valid: stay in IDLE with rom_addr unchanged.
- READ: rsp_data<=rom_data, then go to RESP unconditionally.
- RESP: rsp{owner}_valid=1 and the other rsp valid=0. When rsp{owner}_ready=1, go to IDLE; otherwise hold rsp_data and valid.
- reqN_ready is 0 outside IDLE. Requests arriving during READ/RESP wait, and their valid must stay high.
- Only the owner's rsp_ready is sampled; a rsp_ready on the non-owner port is ignored.
- rsp_data is held constant for the whole RESP state.
- Reset (asynchronous, at any time including mid-transaction):
  - state=IDLE, rom_addr=0, rsp_data=0, owner=0, last_grant=1 (port 0 wins the first tie).
  - Every output is 0: all ready/valid, busy, rom_addr and rsp_data.
  - An in-flight transaction is dropped with no response.

## Timing
- Accept at edge k (ready high in cycle k-1). rom_addr updates at edge k. The word is captured at edge k+1. rspN_valid is high from edge k+1 (after the capture) through the cycle in which rsp_ready is seen.
- Minimum cost per transaction: 3 cycles (IDLE, READ, RESP, with rsp_ready already high). Peak throughput is one word per 3 cycles.
- Both ports continuously valid: grants strictly alternate 0,1,0,1…; no starvation.
- Ready is combinational from reqN_valid and state. There is no combinational path from rom_data to any output.

## Structure
- Shared package (cpu_pkg) holds:
  - the state enum: IDLE=2'd0, READ=2'd1, RESP=2'd2;
  - ROM_ADDR_W=10 and WORD_W=32, which are the parameter defaults here.
- Sub-module rr_arbiter2: two-input round-robin pick. It takes req[1:0] and last_grant and outputs a one-hot grant. It is purely combinational; the last_grant register lives in the parent.
- All state is flopped with async-reset always blocks. ROM content is never touched by this block.

## Test plan
- Single port 0 read: ROM[0x005]=0xDEADBEEF, req0_valid with addr 0x005 at cycle 2, rsp0_ready=1.
  - Required: req0_ready in cycle 2, rom_addr=0x005 after edge 3, rsp0_valid with rsp_data=0xDEADBEEF in cycle 4, busy=0 in cycle 5.
- Tie after reset: both valid, addr0=0x010, addr1=0x020.
  - Required: port 0 granted first, port 1 second.
  - Continuous requests: grant order 0,1,0,1 over 4 transactions, each returning the ROM word of its own address.
- Back-pressure: rsp1_ready held low for 5 cycles.
  - Required: rsp1_valid and rsp_data stable all 5 cycles, no req ready during them, completion on the cycle rsp1_ready rises.
- Wrong-port ready: owner is port 0 and rsp1_ready=1 with rsp0_ready=0.
  - Required: stays in RESP, rsp0_valid remains 1.
- Reset mid-READ: assert rst asynchronously between edges.
  - Required: immediately all outputs 0 and rom_addr=0. After release, a port-1-only request completes normally and its response carries the new address's data.
- Address boundary: addr 0x3FF and then 0x000 return ROM[1023] and ROM[0] respectively.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ROM geometry and the
// ROM port arbiter state encoding.
package cpu_pkg;

  localparam int ROM_ADDR_W = 10;
  localparam int WORD_W     = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rom_port_arbiter_if.sv
// Request/response bundle between the fetch/debug
// requesters (master) and the ROM port arbiter (slave).
interface rom_port_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);

  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic              req1_ready;
  logic              rsp0_valid;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp0_ready;
  logic              rsp1_ready;

  modport master (
    output req0_valid, req0_addr,
    output req1_valid, req1_addr,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_data,
    output rsp0_ready, rsp1_ready
  );

  modport slave (
    input  req0_valid, req0_addr,
    input  req1_valid, req1_addr,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_data,
    input  rsp0_ready, rsp1_ready
  );

endinterface

// File: rtl/rom_port_arbiter_rr.sv
// Two-input round-robin pick; a tie goes to the
// port that did not win last time.
module rr_arbiter2 (
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = i_last_grant ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the instruction ROM read port between
// fetch (port 0) and debug/load (port 1).
module rom_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W,
  parameter int DATA_W = WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  rom_port_arbiter_if.slave bus,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy
);

  arb_state_e        r_state;
  arb_state_e        w_next;
  logic [ADDR_W-1:0] r_rom_addr;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_owner;
  logic              r_last_grant;
  logic [1:0]        w_req;
  logic [1:0]        w_grant;
  logic              w_accept;
  logic [ADDR_W-1:0] w_addr;

  // Gate with rst so ready is low while reset is held.
  assign w_req = {bus.req1_valid, bus.req0_valid}
               & {2{~rst}};

  rr_arbiter2 u_rr (
    .i_req        (w_req),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  assign w_addr = w_grant[1] ? bus.req1_addr
                             : bus.req0_addr;

  always_comb begin
    w_next         = r_state;
    w_accept       = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    case (r_state)
      IDLE: begin
        if (|w_grant) begin
          w_accept       = 1'b1;
          bus.req0_ready = w_grant[0];
          bus.req1_ready = w_grant[1];
          w_next         = READ;
        end
      end
      READ: w_next = RESP;
      RESP: begin
        bus.rsp0_valid = ~r_owner;
        bus.rsp1_valid = r_owner;
        if (r_owner ? bus.rsp1_ready
                    : bus.rsp0_ready)
          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_rom_addr   <= '0;
      r_rsp_data   <= '0;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_rom_addr   <= w_addr;
        r_owner      <= w_grant[1];
        r_last_grant <= w_grant[1];
      end
      if (r_state == READ)
        r_rsp_data <= rom_data;
    end
  end

  assign rom_addr     = r_rom_addr;
  assign bus.rsp_data = r_rsp_data;
  assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter with a
// behavioural ROM driven from rom_addr.
module tb_rom_port_arbiter;

  logic        clk;
  logic        rst;
  logic [9:0]  rom_addr;
  logic [31:0] rom_data;
  logic        busy;
  int          checks;
  int          errors;

  rom_port_arbiter_if #(
    .ADDR_W (10),
    .DATA_W (32)
  ) bus ();

  rom_port_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .busy     (busy)
  );

  function automatic logic [31:0] rom_word(
    input logic [9:0] a
  );
    if (a == 10'h005) return 32'hDEADBEEF;
    return {a, 6'h15, a ^ 10'h3AA, 6'h0B};
  endfunction

  always_comb rom_data = rom_word(rom_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req0_addr  = '0;
    bus.req1_valid = 1'b0;
    bus.req1_addr  = '0;
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;

    // reset state, request held during reset
    step();
    bus.req0_valid = 1'b1;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_addr", rom_addr, 10'h000);
    chk("rst_data", bus.rsp_data, 32'h0);
    chk("rst_rdy0", bus.req0_ready, 1'b0);
    chk("rst_rsp0", bus.rsp0_valid, 1'b0);
    chk("rst_rsp1", bus.rsp1_valid, 1'b0);
    bus.req0_valid = 1'b0;
    step();
    rst = 1'b0;

    // single port 0 read
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 10'h005;
    bus.rsp0_ready = 1'b1;
    #1;
    chk("t1_rdy0", bus.req0_ready, 1'b1);
    chk("t1_rdy1", bus.req1_ready, 1'b0);
    step();
    bus.req0_valid = 1'b0;
    chk("t1_addr", rom_addr, 10'h005);
    chk("t1_busy", busy, 1'b1);
    chk("t1_norsp", bus.rsp0_valid, 1'b0);
    step();
    chk("t1_rsp0", bus.rsp0_valid, 1'b1);
    chk("t1_data", bus.rsp_data, 32'hDEADBEEF);
    step();
    chk("t1_idle", busy, 1'b0);
    chk("t1_rspdn", bus.rsp0_valid, 1'b0);

    // reset asserted mid-READ
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 10'h030;
    #1;
    chk("mr_rdy0", bus.req0_ready, 1'b1);
    step();
    bus.req0_valid = 1'b0;
    chk("mr_read", busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_busy", busy, 1'b0);
    chk("mr_addr", rom_addr, 10'h000);
    chk("mr_data", bus.rsp_data, 32'h0);
    chk("mr_rsp0", bus.rsp0_valid, 1'b0);
    step();
    rst = 1'b0;
    bus.req1_valid = 1'b1;
    bus.req1_addr  = 10'h040;
    bus.rsp1_ready = 1'b1;
    #1;
    chk("mr_rdy1", bus.req1_ready, 1'b1);
    step();
    bus.req1_valid = 1'b0;
    chk("mr_addr1", rom_addr, 10'h040);
    step();
    chk("mr_rsp1", bus.rsp1_valid, 1'b1);
    chk("mr_rsp0b", bus.rsp0_valid, 1'b0);
    chk("mr_dat1", bus.rsp_data, rom_word(10'h040));
    step();
    chk("mr_idle", busy, 1'b0);

    // tie after reset, continuous requests
    rst = 1'b1;
    #1;
    rst = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 10'h010;
    bus.req1_valid = 1'b1;
    bus.req1_addr  = 10'h020;
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_rdy0", bus.req0_ready, (i % 2) == 0);
      chk("rr_rdy1", bus.req1_ready, (i % 2) == 1);
      step();
      step();
      chk("rr_rsp0", bus.rsp0_valid, (i % 2) == 0);
      chk("rr_rsp1", bus.rsp1_valid, (i % 2) == 1);
      chk("rr_data", bus.rsp_data,
          rom_word((i % 2) == 1 ? 10'h020 : 10'h010));
      step();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    #1;

    // back-pressure on port 1
    bus.req1_valid = 1'b1;
    bus.req1_addr  = 10'h077;
    bus.rsp1_ready = 1'b0;
    #1;
    chk("bp_rdy1", bus.req1_ready, 1'b1);
    step();
    bus.req1_valid = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 10'h3FF;
    step();
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp1", bus.rsp1_valid, 1'b1);
      chk("bp_data", bus.rsp_data, rom_word(10'h077));
      chk("bp_nrdy0", bus.req0_ready, 1'b0);
      chk("bp_nrdy1", bus.req1_ready, 1'b0);
      step();
    end
    bus.rsp1_ready = 1'b1;
    #1;
    chk("bp_last", bus.rsp1_valid, 1'b1);
    step();

    // wrong-port ready, top address
    bus.rsp0_ready = 1'b0;
    chk("wp_idle", busy, 1'b0);
    chk("wp_rdy0", bus.req0_ready, 1'b1);
    step();
    bus.req0_valid = 1'b0;
    step();
    chk("wp_rsp0", bus.rsp0_valid, 1'b1);
    chk("wp_top", bus.rsp_data, rom_word(10'h3FF));
    step();
    chk("wp_hold", bus.rsp0_valid, 1'b1);
    chk("wp_busy", busy, 1'b1);
    step();
    chk("wp_hold2", bus.rsp0_valid, 1'b1);
    chk("wp_dat2", bus.rsp_data, rom_word(10'h3FF));
    bus.rsp0_ready = 1'b1;
    step();
    chk("wp_done", busy, 1'b0);

    // bottom address
    bus.req0_valid = 1'b1;
    bus.req0_addr  = 10'h000;
    #1;
    chk("lo_rdy0", bus.req0_ready, 1'b1);
    step();
    bus.req0_valid = 1'b0;
    step();
    chk("lo_rsp0", bus.rsp0_valid, 1'b1);
    chk("lo_data", bus.rsp_data, rom_word(10'h000));
    step();
    chk("lo_idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
